// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared queue entry type and PC step helper for the prefetching fetch unit
package ifu_pkg;
  localparam int IFU_XLEN      = 32;
  localparam int IFU_INSTR_LEN = 32;

  typedef struct packed {
    logic [IFU_INSTR_LEN-1:0] instr;
    logic [IFU_XLEN-1:0]      tag;
  } ifu_entry_t;

  function automatic int ifu_pc_step(input int instr_len);
    return instr_len / 8;
  endfunction

  localparam int IFU_PC_STEP = ifu_pc_step(IFU_INSTR_LEN);
endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous prefetch queue with async reset and synchronous flush
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter type entry_t = ifu_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     wr_data,
  input  logic                       pop,
  output entry_t                     rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - prefetching fetch unit; IFU_PREFETCH_PERF_EN adds fetch/drop counters
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int XLEN       = IFU_XLEN,
  parameter int INSTR_LEN  = IFU_INSTR_LEN,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       reset_vector,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [XLEN-1:0]       mem_req_tag,
  input  logic                  mem_rsp_valid,
  input  logic [INSTR_LEN-1:0]  mem_rsp_data,
  input  logic [XLEN-1:0]       mem_rsp_tag,
  input  logic                  pc_load,
  input  logic [XLEN-1:0]       pc_exu,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [INSTR_LEN-1:0]  instr,
  output logic [XLEN-1:0]       instr_tag
`ifdef IFU_PREFETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_drop_cnt
`endif
);
  localparam int OW      = $clog2(MAX_OUTST + 1);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int PC_STEP = ifu_pc_step(INSTR_LEN);

  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [XLEN-1:0]      tag;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   drop_cnt;
  logic            drain_busy;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  logic [7:0]      credit_sum;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  entry_t          head;
  entry_t          rsp_entry;

  assign drain_busy = (drop_cnt != '0);
  assign credit_sum = 8'(outst) + 8'(fifo_count);
  // Requests in flight plus queued entries never exceed DEPTH, so every response has a slot.
  assign mem_req_valid = !rst && !pc_load && !drain_busy && !fifo_full
                         && (credit_sum < 8'(DEPTH)) && (outst < OW'(MAX_OUTST));
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign mem_req_addr  = mem_req_valid ? pc[ADDR_WIDTH-1:0] : '0;
  assign mem_req_tag   = mem_req_valid ? pc : '0;

  assign rsp_keep  = mem_rsp_valid && !pc_load && !drain_busy;
  assign rsp_entry = '{instr: mem_rsp_data, tag: mem_rsp_tag};

  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_tag   = instr_valid ? head.tag : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= reset_vector;
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      if (pc_load)       pc <= pc_exu;
      else if (req_fire) pc <= pc + XLEN'(PC_STEP);

      case ({req_fire, mem_rsp_valid})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: ;
      endcase

      // Everything still owed after a redirect belongs to the old stream.
      if (pc_load)                          drop_cnt <= mem_rsp_valid ? outst - OW'(1) : outst;
      else if (drain_busy && mem_rsp_valid) drop_cnt <= drop_cnt - OW'(1);
    end
  end

  ifu_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (pc_load),
    .push    (rsp_keep),
    .wr_data (rsp_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef IFU_PREFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (req_fire)                  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (mem_rsp_valid && !rsp_keep) perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed bench with a stream-level model of fetch, drain and delivery
module tb_ifu_prefetch;
  localparam logic [31:0] K = 32'hA5A5_5A5A;

  logic        clk;
  logic        rst;
  logic [31:0] reset_vector;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [15:0] mem_req_addr;
  logic [31:0] mem_req_tag;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] mem_rsp_tag;
  logic        pc_load;
  logic [31:0] pc_exu;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_tag;
`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  ifu_prefetch dut (
    .clk           (clk),
    .rst           (rst),
    .reset_vector  (reset_vector),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_tag   (mem_req_tag),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_tag   (mem_rsp_tag),
    .pc_load       (pc_load),
    .pc_exu        (pc_exu),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_tag     (instr_tag)
`ifdef IFU_PREFETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_drop_cnt (perf_drop_cnt)
`endif
  );

  typedef struct {
    logic [31:0] tag;
    int          due;
    int          gen;
  } req_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] tag;
  } ent_t;

  req_t        pending[$];
  ent_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  int          cyc = 0;
  int          cur_gen = 0;
  int          rsp_gen = 0;
  int          n_acc = 0;
  int          n_drop = 0;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // In-order memory: each accepted request answers `lat` cycles later.
  initial begin
    req_t r;
    mem_rsp_valid = 0;
    mem_rsp_data  = 0;
    mem_rsp_tag   = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        pending.delete();
        mem_rsp_valid = 0;
      end else if (pending.size() > 0 && pending[0].due <= cyc) begin
        r = pending.pop_front();
        mem_rsp_valid = 1;
        mem_rsp_tag   = r.tag;
        mem_rsp_data  = r.tag ^ K;
        rsp_gen       = r.gen;
      end else begin
        mem_rsp_valid = 0;
      end
    end
  end

  // Stream model: a response is delivered only if it belongs to the current fetch stream.
  always @(negedge clk) begin
    int inflight;
    int old;
    logic exp_v;
    if (rst) begin
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_req_tag", mem_req_tag, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_tag", instr_tag, 0);
      pending.delete();
      q.delete();
      m_pc   = reset_vector;
      n_acc  = 0;
      n_drop = 0;
      cur_gen++;
    end else begin
      inflight = pending.size() + (mem_rsp_valid ? 1 : 0);
      old = (mem_rsp_valid && rsp_gen != cur_gen) ? 1 : 0;
      foreach (pending[i]) if (pending[i].gen != cur_gen) old++;
      exp_v = !pc_load && (old == 0) && (inflight + q.size() < 4) && (inflight < 4);
      chk("req_valid", mem_req_valid, exp_v);
      if (exp_v) begin
        chk("req_addr", mem_req_addr, m_pc[15:0]);
        chk("req_tag", mem_req_tag, m_pc);
      end
      chk("instr_valid", instr_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("instr", instr, q[0].instr);
        chk("instr_tag", instr_tag, q[0].tag);
      end
`ifdef IFU_PREFETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, n_acc);
      chk("perf_drop", perf_drop_cnt, n_drop);
`endif
      if (q.size() != 0 && instr_ready) void'(q.pop_front());
      if (mem_rsp_valid) begin
        if (!pc_load && rsp_gen == cur_gen) q.push_back('{mem_rsp_data, mem_rsp_tag});
        else n_drop++;
      end
      if (mem_req_valid && mem_req_ready) begin
        pending.push_back('{m_pc, cyc + lat, cur_gen});
        m_pc = m_pc + 32'd4;
        n_acc++;
      end
      if (pc_load) begin
        cur_gen++;
        q.delete();
        m_pc = pc_exu;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] a0;
    logic [31:0] t0;
    logic [31:0] exp_t;
    logic [31:0] first_tag;
    int nv;
    int nchg;
    int nq;
    int nold;
    rst = 1;
    reset_vector  = 32'h100;
    mem_req_ready = 1;
    instr_ready   = 0;
    pc_load       = 0;
    pc_exu        = 0;
    lat           = 1;
    repeat (3) tick();

    // Fill the queue with decode stalled
    tick();
    rst = 0;
    #2;
    chk("first_req_valid", mem_req_valid, 1);
    chk("first_req_addr", mem_req_addr, 16'h0100);
    repeat (8) tick();
    #2;
    chk("fill_req_valid", mem_req_valid, 0);
    chk("fill_head_tag", instr_tag, 32'h100);
    chk("fill_head_instr", instr, 32'hA5A5_5B5A);
    chk("fill_accepts", n_acc, 4);

    // Sustained one instruction per cycle
    tick();
    instr_ready = 1;
    nv = 0;
    exp_t = 32'h100;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (instr_valid && instr_tag == exp_t) nv++;
      exp_t = exp_t + 32'd4;
      tick();
    end
    chk("stream_count", nv, 12);

    // Request held while memory stalls, then withdrawn by a redirect
    mem_req_ready = 0;
    #2;
    a0 = mem_req_addr;
    t0 = mem_req_tag;
    nchg = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      if (!mem_req_valid || mem_req_addr != a0 || mem_req_tag != t0) nchg++;
    end
    chk("stall_hold", nchg, 0);
    tick();
    pc_load = 1;
    pc_exu  = 32'h300;
    #2;
    chk("withdraw_valid", mem_req_valid, 0);
    tick();
    pc_load = 0;
    #2;
    chk("redirect_valid", mem_req_valid, 1);
    chk("redirect_addr", mem_req_addr, 16'h0300);
    chk("redirect_instr_valid", instr_valid, 0);

    // Three requests in flight when redirected: all three drained
    lat = 4;
    tick();
    mem_req_ready = 1;
    repeat (3) tick();
    pc_load = 1;
    pc_exu  = 32'h200;
    tick();
    pc_load = 0;
    nq = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (!mem_req_valid && !instr_valid) nq++;
      tick();
    end
    #2;
    chk("drain_quiet", nq, 3);
    chk("drain_first_valid", mem_req_valid, 1);
    chk("drain_first_addr", mem_req_addr, 16'h0200);
    nold = 0;
    first_tag = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      #2;
      if (instr_valid && instr_tag[15:8] == 8'h03) nold++;
      if (instr_valid && first_tag == 0) first_tag = instr_tag;
    end
    chk("drain_old_tags", nold, 0);
    chk("drain_first_tag", first_tag, 32'h200);

    // Redirect coinciding with a response, two outstanding
    mem_req_ready = 0;
    repeat (8) tick();
    tick();
    pc_load = 1;
    pc_exu  = 32'h180;
    tick();
    pc_load = 0;
    lat = 2;
    mem_req_ready = 1;
    repeat (2) tick();
    pc_load = 1;
    pc_exu  = 32'h400;
    tick();
    pc_load = 0;
    #2;
    chk("coinc_drop_cnt", dut.drop_cnt, 1);
    chk("coinc_req_valid", mem_req_valid, 0);
    chk("coinc_instr_valid", instr_valid, 0);
    tick();
    #2;
    chk("coinc_next_valid", mem_req_valid, 1);
    chk("coinc_next_addr", mem_req_addr, 16'h0400);

    // Reset pulsed mid-stream
    lat = 1;
    repeat (6) tick();
    tick();
    reset_vector = 32'h500;
    rst = 1;
    #2;
    chk("mid_rst_req_valid", mem_req_valid, 0);
    chk("mid_rst_instr_valid", instr_valid, 0);
    chk("mid_rst_instr_tag", instr_tag, 0);
    chk("mid_rst_req_addr", mem_req_addr, 0);
`ifdef IFU_PREFETCH_PERF_EN
    chk("mid_rst_perf_fetch", perf_fetch_cnt, 0);
    chk("mid_rst_perf_drop", perf_drop_cnt, 0);
`endif
    repeat (2) tick();
    rst = 0;
    #2;
    chk("restart_valid", mem_req_valid, 1);
    chk("restart_addr", mem_req_addr, 16'h0500);
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
